// File: rtl/heartbeat_multi.sv
`default_nettype none
// ============================================================================
// heartbeat_multi : CHANNELS independent programmable heartbeat generators
//                   (off / square / pulse / pwm) with a shared config port.
// Revision        : 1.0
// ============================================================================
module heartbeat_multi #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        cfg_we,
  input  logic [$clog2(CHANNELS)-1:0] cfg_sel,
  input  logic [1:0]                  cfg_field,
  input  logic [WIDTH-1:0]            cfg_wdata,
  input  logic                        resync,
  output logic [CHANNELS-1:0]         out,
  output logic [CHANNELS-1:0]         tick
);

  localparam int SEL_W = $clog2(CHANNELS);

  localparam logic [1:0] FIELD_PERIOD = 2'd0;
  localparam logic [1:0] FIELD_DUTY   = 2'd1;
  localparam logic [1:0] FIELD_MODE   = 2'd2;

  localparam logic [1:0] MODE_OFF    = 2'd0;
  localparam logic [1:0] MODE_SQUARE = 2'd1;
  localparam logic [1:0] MODE_PULSE  = 2'd2;
  localparam logic [1:0] MODE_PWM    = 2'd3;

  localparam logic [WIDTH-1:0] PERIOD_RST = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] DUTY_RST   = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] CNT_ONE    = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [CHANNELS-1:0] we_period;
  logic [CHANNELS-1:0] we_duty;
  logic [CHANNELS-1:0] we_mode;

  // An out-of-range cfg_sel matches no channel, and field 3 sets no strobe.
  always_comb begin
    we_period = '0;
    we_duty   = '0;
    we_mode   = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (cfg_we && (cfg_sel == SEL_W'(i))) begin
        we_period[i] = (cfg_field == FIELD_PERIOD);
        we_duty[i]   = (cfg_field == FIELD_DUTY);
        we_mode[i]   = (cfg_field == FIELD_MODE);
      end
    end
  end

  generate
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      localparam logic [1:0] MODE_RST = (i == 0) ? MODE_SQUARE : MODE_OFF;

      logic [WIDTH-1:0] cnt_q, cnt_d;
      logic [WIDTH-1:0] period_q, period_d;
      logic [WIDTH-1:0] duty_q, duty_d;
      logic [1:0]       mode_q, mode_d;
      logic             out_q, out_d;
      logic             tick_q, tick_d;
      logic             wrap;
      logic [WIDTH-1:0] cnt_next;

      always_comb begin
        wrap     = (cnt_q >= period_q);
        cnt_next = wrap ? '0 : (cnt_q + CNT_ONE);

        period_d = we_period[i] ? cfg_wdata : period_q;
        duty_d   = we_duty[i]   ? cfg_wdata : duty_q;
        mode_d   = we_mode[i]   ? cfg_wdata[1:0] : mode_q;

        cnt_d  = '0;
        out_d  = 1'b0;
        tick_d = 1'b0;

        // The counter always advances against the period held before this
        // edge, so a shrunk period takes effect as a wrap on the next edge.
        if (mode_q != MODE_OFF) begin
          cnt_d  = cnt_next;
          tick_d = wrap;
          case (mode_q)
            MODE_SQUARE: out_d = out_q ^ wrap;
            MODE_PULSE:  out_d = wrap;
            MODE_PWM:    out_d = (cnt_next < duty_q);
            default:     out_d = 1'b0;
          endcase
        end

        if (we_mode[i] || resync) begin
          cnt_d  = '0;
          out_d  = 1'b0;
          tick_d = 1'b0;
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          cnt_q    <= '0;
          period_q <= PERIOD_RST;
          duty_q   <= DUTY_RST;
          mode_q   <= MODE_RST;
          out_q    <= 1'b0;
          tick_q   <= 1'b0;
        end else begin
          cnt_q    <= cnt_d;
          period_q <= period_d;
          duty_q   <= duty_d;
          mode_q   <= mode_d;
          out_q    <= out_d;
          tick_q   <= tick_d;
        end
      end

      assign out[i]  = out_q;
      assign tick[i] = tick_q;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_heartbeat_multi.sv
`default_nettype none
// ============================================================================
// tb_heartbeat_multi : self-checking bench for heartbeat_multi (8-bit, 4 ch)
// Revision           : 1.0
// ============================================================================
module tb_heartbeat_multi;

  logic       clk;
  logic       reset;
  logic       cfg_we;
  logic [1:0] cfg_sel;
  logic [1:0] cfg_field;
  logic [7:0] cfg_wdata;
  logic       resync;
  logic [3:0] out;
  logic [3:0] tick;

  int checks   = 0;
  int failures = 0;

  heartbeat_multi #(.WIDTH(8), .CHANNELS(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .cfg_we    (cfg_we),
    .cfg_sel   (cfg_sel),
    .cfg_field (cfg_field),
    .cfg_wdata (cfg_wdata),
    .resync    (resync),
    .out       (out),
    .tick      (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: per-channel integer state following the channel rules.
  int m_cnt [4];
  int m_p   [4];
  int m_d   [4];
  int m_m   [4];
  bit m_out [4];
  bit m_tick[4];

  function automatic void restart(int c);
    m_cnt[c]  = 0;
    m_out[c]  = 1'b0;
    m_tick[c] = 1'b0;
  endfunction

  function automatic void model_update();
    bit w;
    int nc;
    if (reset) begin
      for (int c = 0; c < 4; c++) begin
        restart(c);
        m_p[c] = 255;
        m_d[c] = 128;
        m_m[c] = (c == 0) ? 1 : 0;
      end
    end else begin
      for (int c = 0; c < 4; c++) begin
        if (m_m[c] == 0) begin
          restart(c);
        end else begin
          w  = (m_cnt[c] >= m_p[c]);
          nc = w ? 0 : m_cnt[c] + 1;
          m_tick[c] = w;
          if (m_m[c] == 1)      m_out[c] = m_out[c] ^ w;
          else if (m_m[c] == 2) m_out[c] = w;
          else                  m_out[c] = (nc < m_d[c]);
          m_cnt[c] = nc;
        end
      end
      if (cfg_we && int'(cfg_sel) < 4 && cfg_field != 2'd3) begin
        case (cfg_field)
          2'd0: m_p[cfg_sel] = int'(cfg_wdata);
          2'd1: m_d[cfg_sel] = int'(cfg_wdata);
          default: begin
            m_m[cfg_sel] = int'(cfg_wdata) % 4;
            restart(int'(cfg_sel));
          end
        endcase
      end
      if (resync) for (int c = 0; c < 4; c++) restart(c);
    end
  endfunction

  function automatic logic [3:0] model_vec(bit sel_tick);
    logic [3:0] v;
    for (int c = 0; c < 4; c++) v[c] = sel_tick ? m_tick[c] : m_out[c];
    return v;
  endfunction

  task automatic check(string name, logic [3:0] act, logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: actual=%b required=%b", name, $time, act, exp);
    end
  endtask

  task automatic check_int(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at %0t: actual=%0d required=%0d", name, $time, act, exp);
    end
  endtask

  task automatic drive(logic r, logic we, logic [1:0] sel, logic [1:0] fld,
                       logic [7:0] wd, logic rs);
    reset     = r;
    cfg_we    = we;
    cfg_sel   = sel;
    cfg_field = fld;
    cfg_wdata = wd;
    resync    = rs;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 2'd0, 2'd0, 8'd0, 1'b0);
  endtask

  // One clock: model follows the inputs sampled at the edge, outputs read 1ns later.
  task automatic step(bit chk);
    @(posedge clk);
    model_update();
    #1;
    if (chk) begin
      check("model_out", out, model_vec(1'b0));
      check("model_tick", tick, model_vec(1'b1));
    end
  endtask

  typedef struct {
    logic       rst;
    logic       we;
    logic [1:0] sel;
    logic [1:0] fld;
    logic [7:0] wd;
    logic       rsy;
    logic [3:0] exp_out;
    logic [3:0] exp_tick;
  } vec_t;

  vec_t tbl[21];

  initial begin
    int n;
    bit found;

    tbl[0]  = '{1'b1, 1'b0, 2'd0, 2'd0, 8'd0, 1'b0, 4'b0000, 4'b0000};
    tbl[1]  = '{1'b0, 1'b1, 2'd1, 2'd0, 8'd3, 1'b0, 4'b0000, 4'b0000};
    tbl[2]  = '{1'b0, 1'b1, 2'd1, 2'd1, 8'd2, 1'b0, 4'b0000, 4'b0000};
    tbl[3]  = '{1'b0, 1'b1, 2'd1, 2'd2, 8'd3, 1'b0, 4'b0000, 4'b0000};
    tbl[4]  = '{1'b0, 1'b0, 2'd0, 2'd0, 8'd0, 1'b0, 4'b0010, 4'b0000};
    tbl[5]  = '{1'b0, 1'b0, 2'd0, 2'd0, 8'd0, 1'b0, 4'b0000, 4'b0000};
    tbl[6]  = '{1'b0, 1'b0, 2'd0, 2'd0, 8'd0, 1'b0, 4'b0000, 4'b0000};
    tbl[7]  = '{1'b0, 1'b0, 2'd0, 2'd0, 8'd0, 1'b0, 4'b0010, 4'b0010};
    tbl[8]  = '{1'b0, 1'b0, 2'd0, 2'd0, 8'd0, 1'b0, 4'b0010, 4'b0000};
    tbl[9]  = '{1'b0, 1'b0, 2'd0, 2'd0, 8'd0, 1'b0, 4'b0000, 4'b0000};
    tbl[10] = '{1'b0, 1'b1, 2'd1, 2'd3, 8'd0, 1'b0, 4'b0000, 4'b0000};
    tbl[11] = '{1'b0, 1'b0, 2'd0, 2'd0, 8'd0, 1'b0, 4'b0010, 4'b0010};
    tbl[12] = '{1'b0, 1'b1, 2'd2, 2'd0, 8'd0, 1'b0, 4'b0010, 4'b0000};
    tbl[13] = '{1'b0, 1'b1, 2'd2, 2'd2, 8'd2, 1'b0, 4'b0000, 4'b0000};
    tbl[14] = '{1'b0, 1'b0, 2'd0, 2'd0, 8'd0, 1'b0, 4'b0100, 4'b0100};
    tbl[15] = '{1'b0, 1'b0, 2'd0, 2'd0, 8'd0, 1'b0, 4'b0110, 4'b0110};
    tbl[16] = '{1'b0, 1'b1, 2'd2, 2'd2, 8'd0, 1'b0, 4'b0010, 4'b0000};
    tbl[17] = '{1'b0, 1'b0, 2'd0, 2'd0, 8'd0, 1'b1, 4'b0000, 4'b0000};
    tbl[18] = '{1'b0, 1'b0, 2'd0, 2'd0, 8'd0, 1'b0, 4'b0010, 4'b0000};
    tbl[19] = '{1'b1, 1'b0, 2'd0, 2'd0, 8'd0, 1'b0, 4'b0000, 4'b0000};
    tbl[20] = '{1'b0, 1'b0, 2'd0, 2'd0, 8'd0, 1'b0, 4'b0000, 4'b0000};

    drive(1'b1, 1'b0, 2'd0, 2'd0, 8'd0, 1'b0);
    step(1'b1);

    // Directed table: ch1 pwm 1,1,0,0, reserved field, ch2 pulse at P=0, resync, reset.
    for (int k = 0; k < 21; k++) begin
      drive(tbl[k].rst, tbl[k].we, tbl[k].sel, tbl[k].fld, tbl[k].wd, tbl[k].rsy);
      step(1'b0);
      check($sformatf("tbl%0d_out", k), out, tbl[k].exp_out);
      check($sformatf("tbl%0d_tick", k), tick, tbl[k].exp_tick);
    end

    // Default configuration: ch0 square with a 256-cycle period.
    drive(1'b1, 1'b0, 2'd0, 2'd0, 8'd0, 1'b0);
    step(1'b1);
    idle();
    for (int half = 0; half < 2; half++) begin
      n = 0;
      found = 1'b0;
      for (int k = 1; k <= 300 && !found; k++) begin
        step(1'b1);
        if (tick[0]) begin
          found = 1'b1;
          n = k;
        end
      end
      check_int($sformatf("tick0_edges_%0d", half), n, 256);
      check($sformatf("out_at_tick0_%0d", half), out, (half == 0) ? 4'b0001 : 4'b0000);
    end

    // Period shrunk below the running count.
    drive(1'b0, 1'b1, 2'd1, 2'd0, 8'd5, 1'b0); step(1'b1);
    drive(1'b0, 1'b1, 2'd1, 2'd2, 8'd1, 1'b0); step(1'b1);
    idle();
    for (int k = 0; k < 4; k++) step(1'b1);
    drive(1'b0, 1'b1, 2'd1, 2'd0, 8'd2, 1'b0); step(1'b1);
    check("shrink_no_tick_yet", {3'b000, tick[1]}, 4'b0000);
    idle();
    step(1'b1);
    check("shrink_wrap_tick", {3'b000, tick[1]}, 4'b0001);
    check("shrink_wrap_out", {3'b000, out[1]}, 4'b0001);
    step(1'b1);
    step(1'b1);
    check("shrink_gap", {3'b000, tick[1]}, 4'b0000);
    step(1'b1);
    check("shrink_tick2", {3'b000, tick[1]}, 4'b0001);
    check("shrink_out2", {3'b000, out[1]}, 4'b0000);

    // Resync coincident with a mode write.
    drive(1'b0, 1'b1, 2'd3, 2'd0, 8'd1, 1'b0); step(1'b1);
    drive(1'b0, 1'b1, 2'd3, 2'd2, 8'd1, 1'b1); step(1'b1);
    check("resync_out", out, 4'b0000);
    check("resync_tick", tick, 4'b0000);
    idle();
    step(1'b1);
    step(1'b1);
    check("resync_ch3_ch0", {out[3], 2'b00, out[0]}, 4'b1000);

    // Reset in the middle of a run with every channel active.
    drive(1'b0, 1'b1, 2'd2, 2'd2, 8'd3, 1'b0); step(1'b1);
    idle();
    for (int k = 0; k < 5; k++) step(1'b1);
    drive(1'b1, 1'b0, 2'd0, 2'd0, 8'd0, 1'b0); step(1'b1);
    check("midreset_out", out, 4'b0000);
    check("midreset_tick", tick, 4'b0000);
    idle();

    // Randomised traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      drive(($urandom_range(0, 399) == 0),
            ($urandom_range(0, 3) == 0),
            2'($urandom_range(0, 3)),
            2'($urandom_range(0, 3)),
            ($urandom_range(0, 3) != 0) ? 8'($urandom_range(0, 9)) : 8'($urandom),
            ($urandom_range(0, 63) == 0));
      step(1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/heartbeat_multi.md
HEARTBEAT_MULTI -- requirements
Module: heartbeat_multi

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the per-channel counter, period and duty width; legal range 2..32.
REQ-002 SHALL have parameter CHANNELS, default 4, giving the number of independent heartbeat channels; legal range 2..16.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state SHALL be updated on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port cfg_we, input, 1 bit: configuration write strobe, single-cycle, no handshake.
REQ-006 SHALL have port cfg_sel, input, $clog2(CHANNELS) bits: target channel of a write.
REQ-007 SHALL have port cfg_field, input, 2 bits: 0=period, 1=duty, 2=mode, 3=reserved (write ignored).
REQ-008 SHALL have port cfg_wdata, input, WIDTH bits: write data; the mode field uses bits [1:0] only.
REQ-009 SHALL have port resync, input, 1 bit: global phase restart of all channels.
REQ-010 SHALL have port out, output, CHANNELS bits: per-channel registered heartbeat output.
REQ-011 SHALL have port tick, output, CHANNELS bits: per-channel registered one-cycle wrap strobe.

Function
REQ-012 Each channel SHALL hold a counter cnt, a period register P, a duty register D and a mode register M.
REQ-013 Modes SHALL be: 0=off, 1=square, 2=pulse, 3=pwm.
REQ-014 In a nonzero mode, on each edge cnt SHALL become 0 if cnt>=P (wrap event), else cnt+1; the period is therefore P+1 cycles.
REQ-015 In mode 0, cnt SHALL be held at 0, out=0 and tick=0.
REQ-016 tick[i] SHALL be 1 in exactly the cycle after a wrap edge, i.e. coincident with cnt==0 after a wrap, and 0 otherwise.
REQ-017 Square mode: out SHALL toggle on each wrap edge.
REQ-018 Pulse mode: out SHALL equal tick.
REQ-019 PWM mode: out SHALL be registered as (next cnt < D); D=0 gives constant 0 and D>P gives constant 1.
REQ-020 A write to period or duty SHALL update the register at that edge without disturbing cnt, out or phase.
REQ-021 If a new P is below the current cnt, the channel SHALL wrap on the next edge per REQ-014.
REQ-022 A write to mode SHALL update M, and at the same edge set that channel's cnt=0, out=0 and tick=0.
REQ-023 A write with cfg_sel>=CHANNELS or cfg_field=3 SHALL have no effect.
REQ-024 On resync=1, every channel SHALL set cnt=0, out=0 and tick=0 at that edge; P, D and M SHALL be unchanged.
REQ-025 If resync and cfg_we occur in the same cycle, the register write SHALL take effect and the counters SHALL restart per REQ-024.
REQ-026 Channels SHALL be fully independent apart from resync and the shared configuration port.

Reset
REQ-027 On reset=1 at an edge: all cnt=0, out=0, tick=0, P=all-ones, D=2^(WIDTH-1), M[0]=1 (square), and M[i]=0 for i>0.
REQ-028 reset SHALL take priority over resync and cfg_we.
REQ-029 A reset mid-period SHALL abort the period, with no residual tick.

Verification (WIDTH=8, CHANNELS=4)
REQ-030 Release reset, no writes -> out[0] toggles every 256 cycles; the first tick[0] occurs 256 cycles after the first non-reset edge; out[3:1]=0.
REQ-031 ch1: P=3, D=2, M=3 -> out[1] repeats 1,1,0,0; tick[1] every 4 cycles, aligned with the first 1.
REQ-032 ch2: P=0, M=2 -> out[2]=tick[2]=1 every cycle; then write M=0 -> both 0 on the next cycle.
REQ-033 ch1: P=5, M=1; at cnt=4 write P=2 -> wrap on the next edge; thereafter tick[1] every 3 cycles; out[1] toggles at each wrap.
REQ-034 resync together with a write ch3 M=1, P=1 -> all cnt=0; ch3 then toggles every 2 cycles, in phase with ch0 restarting from out=0.
REQ-035 Assert reset for 1 cycle mid-run with all channels active -> the state of REQ-027 holds on the next cycle, and there is no tick that cycle.
